// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the RS232 receiver.
// Acknowledges each received byte through a two-state rdy/done handshake and
// queues accepted bytes in a first-word fall-through FIFO. The CPU side can
// pop bytes and read status. When the FIFO is full, a new byte is dropped,
// still acknowledged, and recorded in the sticky overrun flag.
// The block also holds the receiver's baud-select bit.
module uart_rx_ctrl #(
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_done,
  output logic          fsel,
  input  logic          cfg_wr,
  input  logic          cfg_wdata,
  input  logic          rd,
  output logic [7:0]    rd_data,
  output logic          avail,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic          irq
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic          done_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          capture, accept, pop;

  // A byte is taken exactly once, on the cycle the FSM sees rdy from IDLE.
  assign capture = (state == S_IDLE) && rx_rdy;
  // Popping an empty FIFO is a silent no-op.
  assign pop     = rd && (count != '0);
  // When the FIFO is full, a same-cycle pop frees the slot this byte needs.
  assign accept  = capture && (!full || rd);

  // Handshake next state: ack once per byte, then wait for rdy to drop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_rdy) begin
          state_nxt = S_WAIT;
          done_nxt  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!rx_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake state register and registered done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state   <= S_IDLE;
      rx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_done <= done_nxt;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (accept) wp <= wp + AW'(1);
      if (pop)    rp <= rp + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; entries are only read after a write, and avail masks stale data.
    if (accept) mem[wp] <= rx_data;
  end

  // Sticky overrun flag: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)                      overrun <= 1'b0;
    else if (capture && !accept)  overrun <= 1'b1;
    else if (ovr_clr)             overrun <= 1'b0;
  end

  // Baud select; defaults to 115200 after reset.
  always_ff @(posedge clk) begin
    if (rst)         fsel <= 1'b1;
    else if (cfg_wr) fsel <= cfg_wdata;
  end

  assign rd_data = mem[rp];
  assign avail   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign irq     = (count >= THRESH_C);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl (AW=4, DEPTH=16, THRESH=8).
// A table of single-cycle vectors covers the basic handshake, pop and config
// behaviour. Hand-written sequences cover ordering with pointer wrap,
// overrun, a full FIFO with a simultaneous pop, the threshold interrupt, and
// reset in the middle of a transfer.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       fsel;
  logic       cfg_wr;
  logic       cfg_wdata;
  logic       rd;
  logic [7:0] rd_data;
  logic       avail;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;
  logic       irq;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q[$];

  uart_rx_ctrl #(.AW(4), .THRESH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .fsel      (fsel),
    .cfg_wr    (cfg_wr),
    .cfg_wdata (cfg_wdata),
    .rd        (rd),
    .rd_data   (rd_data),
    .avail     (avail),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       cw;
    logic       cwd;
    logic       e_done;
    logic [4:0] e_count;
    logic       e_head_chk;
    logic [7:0] e_head;
    logic       e_ovr;
    logic       e_fsel;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One receiver byte: rdy high for two cycles, then low for one.
  // Exactly one rx_done pulse is expected, in the first cycle.
  task automatic send_byte(input logic [7:0] d);
    logic [2:0] pat;
    rx_rdy  = 1'b1;
    rx_data = d;
    tick();
    pat[2] = rx_done;
    tick();
    pat[1] = rx_done;
    rx_rdy = 1'b0;
    tick();
    pat[0] = rx_done;
    check("done_pulse", 32'(pat), 32'b100);
    if (q.size() < 16) q.push_back(d);
    check("count_after_send", 32'(count), 32'(q.size()));
  endtask

  // Pop one byte and compare the head against the model before it leaves.
  task automatic pop_one();
    check("head", 32'(rd_data), 32'(q[0]));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    void'(q.pop_front());
    check("count_after_pop", 32'(count), 32'(q.size()));
  endtask

  vec_t vecs[7];

  initial begin
    //             rdy data   rd clr cw cwd | done cnt hchk head  ovr fsel
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; cfg_wr = 1'b0; cfg_wdata = 1'b0;
    rd = 1'b0; ovr_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count",   32'(count),   32'd0);
    check("rst_avail",   32'(avail),   32'd0);
    check("rst_full",    32'(full),    32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fsel",    32'(fsel),    32'd1);
    check("rst_done",    32'(rx_done), 32'd0);

    // Table: single byte, pop, pop of an empty FIFO, baud select writes
    for (int i = 0; i < 7; i++) begin
      rx_rdy = vecs[i].rdy; rx_data = vecs[i].data; rd = vecs[i].rd;
      ovr_clr = vecs[i].clr; cfg_wr = vecs[i].cw; cfg_wdata = vecs[i].cwd;
      tick();
      check($sformatf("vec%0d_done", i),  32'(rx_done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_count", i), 32'(count),   32'(vecs[i].e_count));
      check($sformatf("vec%0d_avail", i), 32'(avail),   32'(vecs[i].e_count != 0));
      check($sformatf("vec%0d_ovr", i),   32'(overrun), 32'(vecs[i].e_ovr));
      check($sformatf("vec%0d_fsel", i),  32'(fsel),    32'(vecs[i].e_fsel));
      if (vecs[i].e_head_chk)
        check($sformatf("vec%0d_head", i), 32'(rd_data), 32'(vecs[i].e_head));
    end
    rx_rdy = 1'b0; rd = 1'b0; ovr_clr = 1'b0; cfg_wr = 1'b0;

    // Threshold: 7 bytes keep irq low, the 8th raises it, one pop lowers it
    for (int i = 0; i < 7; i++) send_byte(8'hB0 + 8'(i));
    check("irq_at_7", 32'(irq), 32'd0);
    send_byte(8'hB7);
    check("irq_at_8", 32'(irq), 32'd1);
    pop_one();
    check("irq_after_pop", 32'(irq), 32'd0);
    while (q.size() > 0) pop_one();
    check("thr_drained_avail", 32'(avail), 32'd0);

    // Ordering and pointer wrap: 40 bytes, popped in bursts between sends
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(i));
      if (q.size() >= 12) repeat (5) pop_one();
    end
    while (q.size() > 0) pop_one();
    check("order_drained_avail", 32'(avail), 32'd0);

    // Overrun: fill the FIFO, then send one more byte
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_irq",  32'(irq),  32'd1);
    send_byte(8'h77);
    check("ovr_count",   32'(count),   32'd16);
    check("ovr_flag",    32'(overrun), 32'd1);
    check("ovr_head",    32'(rd_data), 32'h10);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    // A drop and a clear in the same cycle leave the flag set
    rx_rdy = 1'b1; rx_data = 8'h78; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_set_wins_done", 32'(rx_done), 32'd1);
    check("ovr_set_wins",      32'(overrun), 32'd1);
    tick();
    rx_rdy = 1'b0;
    tick();
    check("ovr2_count", 32'(count), 32'd16);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr2_cleared", 32'(overrun), 32'd0);

    // Full FIFO with a pop in the capture cycle: the byte is accepted
    rx_rdy = 1'b1; rx_data = 8'h3C; rd = 1'b1;
    tick();
    rd = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h3C);
    check("fullpop_done",  32'(rx_done), 32'd1);
    check("fullpop_count", 32'(count),   32'd16);
    check("fullpop_ovr",   32'(overrun), 32'd0);
    check("fullpop_head",  32'(rd_data), 32'h11);
    tick();
    rx_rdy = 1'b0;
    tick();
    while (q.size() > 0) pop_one();
    check("fullpop_drained", 32'(count), 32'd0);

    // Reset while in WAIT with five bytes queued and fsel cleared
    cfg_wr = 1'b1; cfg_wdata = 1'b0;
    tick();
    cfg_wr = 1'b0;
    check("cfg_fsel0", 32'(fsel), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    rx_rdy = 1'b1; rx_data = 8'h55;
    tick();
    check("pre_rst_count", 32'(count),   32'd5);
    check("pre_rst_done",  32'(rx_done), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(count),   32'd0);
    check("mid_rst_fsel",  32'(fsel),    32'd1);
    check("mid_rst_ovr",   32'(overrun), 32'd0);
    check("mid_rst_done",  32'(rx_done), 32'd0);
    check("mid_rst_avail", 32'(avail),   32'd0);
    q.delete();
    tick();
    q.push_back(8'h55);
    check("post_rst_done",  32'(rx_done), 32'd1);
    check("post_rst_count", 32'(count),   32'd1);
    tick();
    check("post_rst_done2", 32'(rx_done), 32'd0);
    rx_rdy = 1'b0;
    tick();
    check("post_rst_once", 32'(count), 32'd1);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the RS232 receiver. It consumes bytes via the receiver's rdy/done handshake and buffers them in a DEPTH-entry FIFO. It exposes a CPU-facing read/status interface with overrun and threshold-interrupt flags, and holds the receiver's baud-select configuration bit. It sits between the RS232 receiver and the I/O bus decode.

Parameters:
AW, 4, FIFO address width; DEPTH = 2^AW entries
THRESH, 8, irq asserts when count >= THRESH; legal range 1..DEPTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_rdy  in  1  receiver "byte available" (level)
rx_data  in  8  receiver data, valid while rx_rdy=1
rx_done  out  1  one-cycle ack to receiver ("byte has been read")
fsel  out  1  baud select to receiver (1=115200, 0=19200)
cfg_wr  in  1  config write strobe
cfg_wdata  in  1  new fsel value
rd  in  1  CPU pop strobe, one cycle
rd_data  out  8  FIFO head (first-word fall-through)
avail  out  1  FIFO not empty
full  out  1  count == DEPTH
count  out  AW+1  entries held, 0..DEPTH
overrun  out  1  sticky; a byte was dropped
ovr_clr  in  1  clears overrun
irq  out  1  count >= THRESH

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE, rx_done=0, fsel=1, count=0, wr/rd pointers=0, overrun=0. Hence avail=0, full=0, irq=0. rd_data is don't-care while avail=0.
- Handshake FSM, 2 states:
  - IDLE: on rx_rdy=1, capture rx_data, set rx_done=1 for the next cycle only, go to WAIT.
  - WAIT: rx_done=0. Stay while rx_rdy=1; go to IDLE when rx_rdy=0. This guarantees exactly one capture per receiver byte even though rdy falls one cycle after done.
- Capture rule in IDLE with rx_rdy=1:
  - Accept when count<DEPTH, or when rd=1 and count>0 in the same cycle; write to mem[wp], wp++.
  - Otherwise, discard the byte, set overrun=1, and still ack it (rx_done pulses). The receiver is never stalled.
- Pop: rd=1 with count>0 advances rp. rd with count=0 is ignored, with no state change and no error flag.
- Count: +1 on accept only, -1 on pop only, unchanged when both occur. Pointers wrap modulo DEPTH (AW bits). count is AW+1 bits and never exceeds DEPTH.
- Latency: rx_rdy seen in cycle N → rx_done=1, count updated and rd_data valid (if FIFO was empty) in cycle N+1.
- rd_data = mem[rp], combinational from registered pointer/memory. It updates in the cycle after a pop.
- overrun: set on discard, cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- fsel: cfg_wr=1 loads cfg_wdata at the next edge. The change takes effect immediately; bytes in flight may be corrupted, and this is software's responsibility.
- irq, avail, full: combinational from count.
- Reset mid-operation (FSM in WAIT, FIFO non-empty) returns to the reset state next cycle. No rx_done is emitted in the reset cycle. If rx_rdy is still high afterwards, that byte is captured once from IDLE.
- Memory: DEPTH×8 register array, no reset of contents required.

Test Plan:
- Single byte: rx_rdy rises with 0xA5 and falls 2 cycles later → exactly one rx_done pulse at N+1; count=1, avail=1, rd_data=0xA5. After rd: count=0, avail=0.
- Ordering/wrap: 40 bytes 0x00..0x27 (DEPTH=16), CPU pops between bursts → read sequence exactly 0x00..0x27, count never >16, pointers wrap correctly.
- Overrun: fill 16 bytes without reads, send 0x77 → rx_done still pulses, count stays 16, overrun=1, head still first byte. ovr_clr → overrun=0. ovr_clr coincident with a new discard → overrun stays 1.
- Full + simultaneous pop: count=16, rd asserted in the capture cycle with 0x3C → accepted, count stays 16, overrun=0, 0x3C emerges last.
- Threshold/empty pop: 7 bytes → irq=0; 8th → irq=1; one rd → irq=0. rd with count=0 → count stays 0, no flag changes.
- Config/reset: cfg_wr with cfg_wdata=0 → fsel=0. rst asserted in WAIT with count=5 → next cycle count=0, fsel=1, overrun=0, rx_done=0; rx_rdy still high → captured once after reset.
